// File: rtl/pulse_counter_scheduler_pkg.sv
// Shared types and constants for the pulse counter window scheduler.
// Provides the window FSM state enum, the channel-index width helper and default parameters.
package pulse_counter_pkg;

    localparam int DEF_CHANNELS     = 12;
    localparam int DEF_RESOLUTION   = 32;
    localparam int DEF_WINDOW_BITS  = 24;
    localparam int DEF_CLEAR_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        INTEGRATE,
        LATCH
    } win_state_t;

    // Width needed to index n items; never below 1 bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CHAN_W = chan_w(DEF_CHANNELS);

endpackage

// File: rtl/pulse_counter_scheduler_if.sv
// Snapshot readout stream: one channel word per beat, valid/ready handshake.
// master: out_data, out_channel, out_valid, out_last driven; out_ready sampled. slave: reverse.
interface pulse_counter_scheduler_if
    import pulse_counter_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int RESOLUTION = DEF_RESOLUTION
);

    logic [RESOLUTION-1:0]       out_data;
    logic [chan_w(CHANNELS)-1:0] out_channel;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;

    modport master (
        output out_data,
        output out_channel,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_channel,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/pulse_counter_scheduler_drain.sv
// Shadow register bank holding one snapshot, drained one channel per accepted beat.
// Ports: clk, reset, load (capture request), counts (bank input), stream (master), full.
module snapshot_drain
    import pulse_counter_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int RESOLUTION = DEF_RESOLUTION
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [CHANNELS*RESOLUTION-1:0] counts,
    pulse_counter_scheduler_if.master      stream,
    output logic                           full
);

    localparam int CW = chan_w(CHANNELS);
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    logic [CHANNELS*RESOLUTION-1:0] shadow;
    logic [CW-1:0]                  chan;
    logic                           fire;
    logic                           fire_last;

    assign fire      = full & stream.out_ready;
    assign fire_last = fire & (chan == LAST_CH);

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            chan <= '0;
        end else begin
            if (fire) begin
                chan <= fire_last ? '0 : chan + 1'b1;
            end
            if (fire_last) begin
                full <= 1'b0;
            end
            // A final beat leaving this cycle frees the bank for a new snapshot.
            if (load && (!full || fire_last)) begin
                shadow <= counts;
                full   <= 1'b1;
            end
        end
    end

    // valid and the selected word come only from registers, never from ready.
    assign stream.out_valid   = full;
    assign stream.out_channel = chan;
    assign stream.out_last    = full && (chan == LAST_CH);
    assign stream.out_data    = full ? shadow[int'(chan)*RESOLUTION +: RESOLUTION]
                                     : '0;

endmodule

// File: rtl/pulse_counter_scheduler.sv
// Window sequencer for a pulse counter bank: clear, integrate, snapshot, re-arm.
// Ports: clk, reset, enable, window_len, counts in; counter_reset, window_id, overrun out; stream master.
module pulse_counter_scheduler
    import pulse_counter_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int RESOLUTION   = DEF_RESOLUTION,
    parameter int WINDOW_BITS  = DEF_WINDOW_BITS,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [WINDOW_BITS-1:0]         window_len,
    input  logic [CHANNELS*RESOLUTION-1:0] counts,
    output logic                           counter_reset,
    pulse_counter_scheduler_if.master      stream,
    output logic [15:0]                    window_id,
    output logic                           overrun
);

    localparam int CLR_W = chan_w(CLEAR_CYCLES);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

    win_state_t             state;
    logic [CLR_W-1:0]       clr_cnt;
    logic [WINDOW_BITS-1:0] remain;
    logic                   load;
    logic                   full;
    logic                   dropped;

    assign load = (state == LATCH);

    // The drain frees the bank on the same edge as its final beat.
    assign dropped = full &&
        !(stream.out_valid && stream.out_ready && stream.out_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            counter_reset <= 1'b1;
            clr_cnt       <= '0;
            remain        <= '0;
            window_id     <= '0;
            overrun       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state         <= INTEGRATE;
                        counter_reset <= 1'b0;
                        remain        <= (window_len == '0) ?
                                         WINDOW_BITS'(1) : window_len;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                INTEGRATE: begin
                    if (remain == WINDOW_BITS'(1)) begin
                        state <= LATCH;
                    end else begin
                        remain <= remain - 1'b1;
                    end
                end
                LATCH: begin
                    window_id     <= window_id + 16'd1;
                    counter_reset <= 1'b1;
                    clr_cnt       <= '0;
                    if (dropped) begin
                        overrun <= 1'b1;
                    end
                    state <= enable ? CLEAR : IDLE;
                end
                default: begin
                    state         <= IDLE;
                    counter_reset <= 1'b1;
                end
            endcase
        end
    end

    snapshot_drain #(
        .CHANNELS   (CHANNELS),
        .RESOLUTION (RESOLUTION)
    ) u_drain (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .counts (counts),
        .stream (stream),
        .full   (full)
    );

endmodule
